// File: rtl/switch_pkg.sv
// Shared types and constants for the crossbar frame scheduler.
package switch_pkg;

   localparam int N_PORTS_DEF = 4;
   localparam int DEST_W_DEF  = $clog2(N_PORTS_DEF);

   typedef logic [DEST_W_DEF-1:0] port_idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } out_state_e;

   // Round-robin successor of a port index
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int N_PORTS = 4,
   localparam int DEST_W  = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [DEST_W-1:0]  ptr,
   output logic [N_PORTS-1:0] gnt,
   output logic [DEST_W-1:0]  gnt_idx,
   output logic               found
);

   logic [DEST_W:0]   sum_s;
   logic [DEST_W-1:0] idx_s;

   // Scan from ptr upward modulo N_PORTS, keep the first hit
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum_s   = '0;
      idx_s   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         sum_s = {1'b0, ptr} + (DEST_W+1)'(k);
         if (sum_s >= (DEST_W+1)'(N_PORTS)) begin
            sum_s = sum_s - (DEST_W+1)'(N_PORTS);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[DEST_W-1:0];
         if (!found && req[idx_s]) begin
            gnt[idx_s] = 1'b1;
            gnt_idx    = idx_s;
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/switch_scheduler.sv
// Per-output round-robin frame scheduler driving crossbar selects and per-input grants.
module switch_scheduler
   import switch_pkg::*;
#(
   parameter  int N_PORTS = N_PORTS_DEF,
   localparam int DEST_W  = $clog2(N_PORTS)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_PORTS-1:0]          req_valid_i,
   input  logic [N_PORTS*DEST_W-1:0]   req_dest_i,
   input  logic [N_PORTS-1:0]          eop_i,
   output logic [N_PORTS-1:0]          grant_o,
   output logic [N_PORTS*DEST_W-1:0]   sel_o,
   output logic [N_PORTS-1:0]          out_busy_o
);

   out_state_e          state_r [N_PORTS];
   logic [DEST_W-1:0]   sel_r   [N_PORTS];
   logic [DEST_W-1:0]   ptr_r   [N_PORTS];
   logic [DEST_W-1:0]   dest_r  [N_PORTS];
   logic [N_PORTS-1:0]  grant_r;

   logic [N_PORTS-1:0]  cand_s    [N_PORTS];
   logic [N_PORTS-1:0]  win_s     [N_PORTS];
   logic [DEST_W-1:0]   win_idx_s [N_PORTS];
   logic [N_PORTS-1:0]  win_any_s;
   logic [N_PORTS-1:0]  take_s;
   logic [N_PORTS-1:0]  rel_s;
   logic [N_PORTS-1:0]  grant_nxt_s;

   // Candidate matrix: ungranted, valid inputs addressing each output
   always_comb begin
      for (int j = 0; j < N_PORTS; j++) begin
         cand_s[j] = '0;
         for (int i = 0; i < N_PORTS; i++) begin
            if (req_valid_i[i] && !grant_r[i] &&
                (req_dest_i[i*DEST_W +: DEST_W] == DEST_W'(j))) begin
               cand_s[j][i] = 1'b1;
            end else begin
               cand_s[j][i] = 1'b0;
            end
         end
      end
   end

   for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
      rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
         .req     (cand_s[j]),
         .ptr     (ptr_r[j]),
         .gnt     (win_s[j]),
         .gnt_idx (win_idx_s[j]),
         .found   (win_any_s[j])
      );
   end

   // Releases and new wins per output; an output never does both in one cycle
   always_comb begin
      take_s      = '0;
      rel_s       = '0;
      grant_nxt_s = grant_r;
      for (int j = 0; j < N_PORTS; j++) begin
         take_s[j] = (state_r[j] == IDLE) && win_any_s[j];
         rel_s[j]  = (state_r[j] == BUSY) && eop_i[sel_r[j]] &&
                     (dest_r[sel_r[j]] == DEST_W'(j));
         if (rel_s[j]) begin
            grant_nxt_s[sel_r[j]] = 1'b0;
         end else if (take_s[j]) begin
            grant_nxt_s = grant_nxt_s | win_s[j];
         end else begin
            grant_nxt_s = grant_nxt_s;
         end
      end
   end

   // Output FSMs, owner/pointer registers and per-input latched destination
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         grant_r <= '0;
         for (int j = 0; j < N_PORTS; j++) begin
            state_r[j] <= IDLE;
            sel_r[j]   <= '0;
            ptr_r[j]   <= '0;
            dest_r[j]  <= '0;
         end
      end else begin
         grant_r <= grant_nxt_s;
         for (int j = 0; j < N_PORTS; j++) begin
            case (state_r[j])
               IDLE: begin
                  if (take_s[j]) begin
                     state_r[j] <= BUSY;
                     sel_r[j]   <= win_idx_s[j];
                     ptr_r[j]   <= DEST_W'(wrap_inc(int'(win_idx_s[j]), N_PORTS));
                  end
               end
               BUSY: begin
                  if (rel_s[j]) begin
                     state_r[j] <= IDLE;
                  end
               end
               default: state_r[j] <= IDLE;
            endcase
         end
         for (int i = 0; i < N_PORTS; i++) begin
            if (!grant_r[i] && grant_nxt_s[i]) begin
               dest_r[i] <= req_dest_i[i*DEST_W +: DEST_W];
            end
         end
      end
   end

   // Flatten register state onto the output buses
   always_comb begin
      sel_o      = '0;
      out_busy_o = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         sel_o[j*DEST_W +: DEST_W] = sel_r[j];
         out_busy_o[j]             = (state_r[j] == BUSY);
      end
   end

   assign grant_o = grant_r;

endmodule

// File: tb/tb_switch_scheduler.sv
// Directed and randomized checks of the 4-port switch_scheduler.
module tb_switch_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] req_dest;
   logic [3:0] eop;
   logic [3:0] grant;
   logic [7:0] sel;
   logic [3:0] busy;

   int errors = 0;
   int checks = 0;

   switch_scheduler #(.N_PORTS(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_dest_i  (req_dest),
      .eop_i       (eop),
      .grant_o     (grant),
      .sel_o       (sel),
      .out_busy_o  (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] sel_of(input int j);
      return sel[j*2 +: 2];
   endfunction

   task automatic do_reset;
      req_valid = 4'b0000;
      req_dest  = 8'h00;
      eop       = 4'b0000;
      rst       = 1'b0;
      tick();
      rst       = 1'b1;
   endtask

   task automatic test_reset;
      rst       = 1'b0;
      eop       = 4'b0000;
      req_dest  = 8'h00;
      req_valid = 4'b0011;
      tick();
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=%b", grant, 4'b0000); end
      checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rst_busy got=%b exp=%b", busy, 4'b0000); end
      checks++; if (sel !== 8'h00) begin errors++; $display("FAIL rst_sel got=%h exp=%h", sel, 8'h00); end
      #2 rst = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_nogrant_before_edge got=%b exp=%b", grant, 4'b0000); end
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=%b", grant, 4'b0001); end
      checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL rst_first_busy got=%b exp=%b", busy, 4'b0001); end
   endtask

   task automatic test_round_robin;
      int ord [4] = '{0, 1, 2, 0};
      logic [3:0] exp_g;
      do_reset();
      req_dest  = 8'b00_11_11_11;
      req_valid = 4'b0111;
      for (int k = 0; k < 4; k++) begin
         exp_g = 4'b0001 << ord[k];
         tick();
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, exp_g); end
         checks++; if (sel_of(3) !== 2'(ord[k])) begin errors++; $display("FAIL rr_sel%0d got=%0d exp=%0d", k, sel_of(3), ord[k]); end
         checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL rr_busy%0d got=%b exp=%b", k, busy, 4'b1000); end
         if (k == 0) begin
            tick();
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_hold got=%b exp=%b", grant, exp_g); end
         end
         eop = exp_g;
         tick();
         eop = 4'b0000;
         checks++; if (grant !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL rr_bubble%0d got=%b/%b exp=0000/0000", k, grant, busy); end
         checks++; if (sel_of(3) !== 2'(ord[k])) begin errors++; $display("FAIL rr_selhold%0d got=%0d exp=%0d", k, sel_of(3), ord[k]); end
      end
   endtask

   task automatic test_parallel;
      do_reset();
      req_dest  = 8'b00_11_00_01;
      req_valid = 4'b0111;
      tick();
      checks++; if (grant !== 4'b0111) begin errors++; $display("FAIL par_grant got=%b exp=%b", grant, 4'b0111); end
      checks++; if (busy !== 4'b1011) begin errors++; $display("FAIL par_busy got=%b exp=%b", busy, 4'b1011); end
      checks++; if (sel !== 8'h81) begin errors++; $display("FAIL par_sel got=%h exp=%h", sel, 8'h81); end
   endtask

   task automatic test_owner_ignore;
      do_reset();
      req_dest  = 8'b00_00_10_00;
      req_valid = 4'b0010;
      tick();
      checks++; if (grant !== 4'b0010 || busy !== 4'b0100) begin errors++; $display("FAIL ign_grant got=%b/%b exp=0010/0100", grant, busy); end
      req_dest  = 8'b00_00_00_00;
      req_valid = 4'b0000;
      eop       = 4'b0100;
      tick();
      tick();
      checks++; if (grant !== 4'b0010 || busy !== 4'b0100) begin errors++; $display("FAIL ign_held got=%b/%b exp=0010/0100", grant, busy); end
      checks++; if (sel !== 8'h10) begin errors++; $display("FAIL ign_sel got=%h exp=%h", sel, 8'h10); end
      eop       = 4'b0010;
      req_dest  = 8'b10_00_00_00;
      req_valid = 4'b1000;
      tick();
      eop       = 4'b0000;
      checks++; if (grant !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL ign_release got=%b/%b exp=0000/0000", grant, busy); end
      tick();
      checks++; if (grant !== 4'b1000 || sel_of(2) !== 2'd3) begin errors++; $display("FAIL ign_next got=%b sel=%0d exp=1000 sel=3", grant, sel_of(2)); end
   endtask

   task automatic test_async_reset;
      do_reset();
      req_dest  = 8'h00;
      req_valid = 4'b0001;
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ar_pre got=%b exp=%b", grant, 4'b0001); end
      req_valid = 4'b0011;
      tick();
      #2 rst = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL ar_clear got=%b/%b exp=0000/0000", grant, busy); end
      #2 rst = 1'b1;
      tick();
      checks++; if (grant !== 4'b0001 || sel_of(0) !== 2'd0) begin errors++; $display("FAIL ar_ptr got=%b sel=%0d exp=0001 sel=0", grant, sel_of(0)); end
   endtask

   task automatic test_random;
      logic [1:0] lat [4];
      logic [7:0] drv_dest;
      logic [3:0] drv_valid;
      logic [3:0] prev_g;
      do_reset();
      for (int i = 0; i < 4; i++) lat[i] = 2'd0;
      for (int c = 0; c < 1500; c++) begin
         req_valid = 4'($urandom);
         req_dest  = 8'($urandom);
         eop       = 4'($urandom) & 4'($urandom);
         drv_dest  = req_dest;
         drv_valid = req_valid;
         prev_g    = grant;
         tick();
         for (int i = 0; i < 4; i++) begin
            if (grant[i] && !prev_g[i]) begin
               lat[i] = drv_dest[i*2 +: 2];
               checks++; if (!drv_valid[i]) begin errors++; $display("FAIL rnd_spurious c=%0d in=%0d valid=%b", c, i, drv_valid[i]); end
            end
         end
         checks++; if ($countones(grant) != $countones(busy)) begin errors++; $display("FAIL rnd_count c=%0d grant=%b busy=%b", c, grant, busy); end
         for (int j = 0; j < 4; j++) begin
            if (busy[j]) begin
               checks++; if (grant[sel_of(j)] !== 1'b1 || lat[sel_of(j)] !== 2'(j)) begin
                  errors++; $display("FAIL rnd_owner c=%0d out=%0d sel=%0d dest=%0d", c, j, sel_of(j), lat[sel_of(j)]);
               end
               for (int k = j + 1; k < 4; k++) begin
                  checks++; if (busy[k] && sel_of(k) === sel_of(j)) begin errors++; $display("FAIL rnd_dup c=%0d out=%0d,%0d sel=%0d", c, j, k, sel_of(j)); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_parallel();
      test_owner_ignore();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
